// File: rtl/maxima_uart_tx.sv
// Snapshots the peak-finder maxima array on its completion strobe and sends it as a framed 8N1 byte stream.
// Optional trailing checksum byte enabled by defining MAXIMA_TX_CHECKSUM_EN.
`timescale 1ns/1ps

module maxima_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_MAXIMA   = 16,
  parameter int unsigned MAXIMA_W     = 25,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MAXIMA_W-1:0] maximas [NUM_MAXIMA],
  input  logic                maximas_valid,
  output logic                uart_tx,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DATA_BYTES = 4 * NUM_MAXIMA;
`ifdef MAXIMA_TX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN  = DATA_BYTES + 2;
`else
  localparam int unsigned FRAME_LEN  = DATA_BYTES + 1;
`endif
  localparam int unsigned BYTE_W     = $clog2(FRAME_LEN);
  localparam int unsigned WIDX_W     = (NUM_MAXIMA > 1) ? $clog2(NUM_MAXIMA) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, cnt_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic [BYTE_W-1:0]   byte_idx, byte_idx_nxt;
  logic                tx_nxt, busy_nxt, done_nxt, overrun_nxt;
  logic                accept, bit_end;
  logic [MAXIMA_W-1:0] snap [NUM_MAXIMA];

  logic [BYTE_W-1:0]   data_off;
  logic [WIDX_W-1:0]   word_idx;
  logic [31:0]         word_sel;
  logic [7:0]          lane_byte;
  logic [7:0]          cur_byte;

`ifdef MAXIMA_TX_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  // Byte currently on the line, decoded straight from the byte index
  always_comb begin
    data_off = byte_idx - BYTE_W'(1);
    word_idx = WIDX_W'(data_off >> 2);
    word_sel = '0;
    for (int unsigned k = 0; k < NUM_MAXIMA; k++) begin
      if (word_idx == WIDX_W'(k)) word_sel = 32'(snap[k]);
    end
    case (data_off[1:0])
      2'd0:    lane_byte = word_sel[31:24];
      2'd1:    lane_byte = word_sel[23:16];
      2'd2:    lane_byte = word_sel[15:8];
      default: lane_byte = word_sel[7:0];
    endcase
    if (byte_idx == '0) begin
      cur_byte = SYNC_BYTE;
`ifdef MAXIMA_TX_CHECKSUM_EN
    end else if (byte_idx == BYTE_LAST) begin
      cur_byte = csum;
`endif
    end else begin
      cur_byte = lane_byte;
    end
  end

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = bit_cnt;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    accept       = 1'b0;
    overrun_nxt  = overrun;
    tx_nxt       = 1'b1;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    bit_end      = (bit_cnt == CNT_LAST);

    case (state)
      S_IDLE: begin
        if (maximas_valid) begin
          accept       = 1'b1;
          state_nxt    = S_START;
          cnt_nxt      = '0;
          bit_idx_nxt  = '0;
          byte_idx_nxt = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt   = S_DATA;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end else begin
          cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          if (byte_idx == BYTE_LAST) begin
            state_nxt    = S_DONE;
            byte_idx_nxt = '0;
          end else begin
            state_nxt    = S_START;
            byte_idx_nxt = byte_idx + BYTE_W'(1);
          end
        end else begin
          cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (maximas_valid && (state != S_IDLE)) overrun_nxt = 1'b1;

    // Outputs follow the state being entered so they change on the same edge
    case (state_nxt)
      S_START: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      S_DATA: begin
        tx_nxt   = cur_byte[bit_idx_nxt];
        busy_nxt = 1'b1;
      end
      S_STOP:  busy_nxt = 1'b1;
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      byte_idx   <= byte_idx_nxt;
      uart_tx    <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
      overrun    <= overrun_nxt;
    end
  end

  // Frame snapshot; datapath only, no reset needed
  always_ff @(posedge clk) begin
    if (!reset && accept) snap <= maximas;
  end

`ifdef MAXIMA_TX_CHECKSUM_EN
  // Sum of maxima bytes, added as each one finishes its stop bit
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      csum <= '0;
    end else if ((state == S_STOP) && bit_end &&
                 (byte_idx != '0) && (byte_idx != BYTE_LAST)) begin
      csum <= csum + cur_byte;
    end
  end
`endif

endmodule
